// File: rtl/midi_pkg.sv
// Shared MIDI types: event type enum, queued event record, status nibbles
// and the small decode helpers used by the parser.
package midi_pkg;

   typedef enum logic [2:0] {
      EVT_NOTE_OFF = 3'd0,
      EVT_NOTE_ON  = 3'd1,
      EVT_POLY_AT  = 3'd2,
      EVT_CTRL     = 3'd3,
      EVT_PROG     = 3'd4,
      EVT_CHAN_AT  = 3'd5,
      EVT_BEND     = 3'd6
   } evt_type_e;

   typedef struct packed {
      evt_type_e   typ;
      logic [3:0]  chan;
      logic [6:0]  d1;
      logic [6:0]  d2;
   } midi_evt_t;

   typedef enum logic [1:0] {
      PS_IDLE    = 2'd0,
      PS_WAIT_D1 = 2'd1,
      PS_WAIT_D2 = 2'd2,
      PS_SKIP    = 2'd3
   } parse_state_e;

   localparam logic [3:0] ST_NOTE_OFF = 4'h8;
   localparam logic [3:0] ST_NOTE_ON  = 4'h9;
   localparam logic [3:0] ST_POLY_AT  = 4'hA;
   localparam logic [3:0] ST_CTRL     = 4'hB;
   localparam logic [3:0] ST_PROG     = 4'hC;
   localparam logic [3:0] ST_CHAN_AT  = 4'hD;
   localparam logic [3:0] ST_BEND     = 4'hE;

   function automatic evt_type_e status_to_type(input logic [3:0] nib);
      case (nib)
         ST_NOTE_ON: return EVT_NOTE_ON;
         ST_POLY_AT: return EVT_POLY_AT;
         ST_CTRL:    return EVT_CTRL;
         ST_PROG:    return EVT_PROG;
         ST_CHAN_AT: return EVT_CHAN_AT;
         ST_BEND:    return EVT_BEND;
         default:    return EVT_NOTE_OFF;
      endcase
   endfunction

   function automatic logic is_two_byte(input logic [3:0] nib);
      return (nib == ST_PROG) || (nib == ST_CHAN_AT);
   endfunction

endpackage

// File: rtl/midi_evt_fifo.sv
// First-word-fall-through event queue; head is forced to zero while empty so
// the consumer never sees stale contents.
module midi_evt_fifo
   import midi_pkg::*;
#(
   parameter int DEPTH = 4
)(
   input  logic      clk,
   input  logic      rst,
   input  logic      in_valid,
   input  midi_evt_t in_data,
   output logic      in_ready,
   output logic      out_valid,
   output midi_evt_t out_data,
   input  logic      out_ready
);

   localparam int AW = $clog2(DEPTH);

   midi_evt_t         mem [DEPTH];
   logic [AW-1:0]     wr_ptr_reg, rd_ptr_reg;
   logic [AW:0]       count_reg, count_next;
   logic              full, wr_en, rd_en;

   assign full      = (count_reg == (AW+1)'(DEPTH));
   assign out_valid = (count_reg != '0);
   assign rd_en     = out_valid && out_ready;
   // A pop in the same cycle frees the slot the push is about to use.
   assign in_ready  = !full || rd_en;
   assign wr_en     = in_valid && in_ready;
   assign out_data  = out_valid ? mem[rd_ptr_reg] : '0;

   always_comb begin
      count_next = count_reg;
      case ({wr_en, rd_en})
         2'b10:   count_next = count_reg + 1'b1;
         2'b01:   count_next = count_reg - 1'b1;
         default: count_next = count_reg;
      endcase
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr_reg] <= in_data;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (wr_en) wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (rd_en) rd_ptr_reg <= rd_ptr_reg + 1'b1;
         count_reg <= count_next;
      end
   end

endmodule

// File: rtl/midi_event_decoder.sv
// MIDI byte-stream parser with running status; completed channel-voice
// messages are registered once and queued in an event FIFO.
module midi_event_decoder
   import midi_pkg::*;
#(
   parameter logic [15:0] CHAN_MASK   = 16'hFFFF,
   parameter int          FIFO_DEPTH  = 4,
   parameter bit          VEL0_IS_OFF = 1'b1
)(
   input  logic       clk,
   input  logic       rst,
   input  logic       byte_valid,
   input  logic [7:0] byte_data,
   output logic       evt_valid,
   input  logic       evt_ready,
   output logic [2:0] evt_type,
   output logic [3:0] evt_chan,
   output logic [6:0] evt_d1,
   output logic [6:0] evt_d2,
   output logic       overflow,
   output logic [7:0] drop_cnt
);

   parse_state_e state_reg, state_next;
   logic [7:0]   status_reg, status_next;
   logic [6:0]   d1_reg, d1_next;
   logic         push_reg, push_next;
   midi_evt_t    evt_reg, evt_next;
   logic         complete;
   logic [6:0]   cd1, cd2;
   logic         fifo_in_ready, drop;
   logic         overflow_reg;
   logic [7:0]   drop_cnt_reg;
   midi_evt_t    head;

   always_comb begin
      state_next  = state_reg;
      status_next = status_reg;
      d1_next     = d1_reg;
      push_next   = 1'b0;
      evt_next    = '0;
      complete    = 1'b0;
      cd1         = '0;
      cd2         = '0;
      if (byte_valid) begin
         if (byte_data[7]) begin
            if (byte_data[7:4] != 4'hF) begin
               status_next = byte_data;
               d1_next     = '0;
               state_next  = PS_WAIT_D1;
            end else if (!byte_data[3]) begin
               // F0-F7 kill running status; F8-FF fall through untouched.
               status_next = '0;
               state_next  = (byte_data == 8'hF0) ? PS_SKIP : PS_IDLE;
            end
         end else begin
            case (state_reg)
               PS_WAIT_D1: begin
                  if (is_two_byte(status_reg[7:4])) begin
                     complete = 1'b1;
                     cd1      = byte_data[6:0];
                  end else begin
                     d1_next    = byte_data[6:0];
                     state_next = PS_WAIT_D2;
                  end
               end
               PS_WAIT_D2: begin
                  complete   = 1'b1;
                  cd1        = d1_reg;
                  cd2        = byte_data[6:0];
                  state_next = PS_WAIT_D1;
               end
               default: ;
            endcase
         end
      end
      if (complete) begin
         evt_next.typ  = status_to_type(status_reg[7:4]);
         if (VEL0_IS_OFF && (evt_next.typ == EVT_NOTE_ON) && (cd2 == '0))
            evt_next.typ = EVT_NOTE_OFF;
         evt_next.chan = status_reg[3:0];
         evt_next.d1   = cd1;
         evt_next.d2   = cd2;
         push_next     = CHAN_MASK[status_reg[3:0]];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg  <= PS_IDLE;
         status_reg <= '0;
         d1_reg     <= '0;
         push_reg   <= 1'b0;
         evt_reg    <= '0;
      end else begin
         state_reg  <= state_next;
         status_reg <= status_next;
         d1_reg     <= d1_next;
         push_reg   <= push_next;
         evt_reg    <= evt_next;
      end
   end

   midi_evt_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (push_reg),
      .in_data   (evt_reg),
      .in_ready  (fifo_in_ready),
      .out_valid (evt_valid),
      .out_data  (head),
      .out_ready (evt_ready)
   );

   assign drop = push_reg && !fifo_in_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         overflow_reg <= 1'b0;
         drop_cnt_reg <= '0;
      end else if (drop) begin
         overflow_reg <= 1'b1;
         if (drop_cnt_reg != 8'hFF) drop_cnt_reg <= drop_cnt_reg + 1'b1;
      end
   end

   assign overflow = overflow_reg;
   assign drop_cnt = drop_cnt_reg;
   assign evt_type = head.typ;
   assign evt_chan = head.chan;
   assign evt_d1   = head.d1;
   assign evt_d2   = head.d2;

endmodule

// File: tb/tb_midi_event_decoder.sv
// Directed test of the MIDI event decoder: running status, realtime, sysex,
// overflow/drop counting, channel masking and reset behaviour.
module tb_midi_event_decoder;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       byte_valid = 1'b0;
   logic [7:0] byte_data = '0;
   logic       evt_ready = 1'b0;

   logic       a_valid, a_ovf, b_valid, b_ovf;
   logic [2:0] a_type, b_type;
   logic [3:0] a_chan, b_chan;
   logic [6:0] a_d1, a_d2, b_d1, b_d2;
   logic [7:0] a_drop, b_drop;

   int tests_run    = 0;
   int tests_failed = 0;

   always #5 clk = ~clk;

   midi_event_decoder dut_a (
      .clk(clk), .rst(rst), .byte_valid(byte_valid), .byte_data(byte_data),
      .evt_valid(a_valid), .evt_ready(evt_ready), .evt_type(a_type),
      .evt_chan(a_chan), .evt_d1(a_d1), .evt_d2(a_d2),
      .overflow(a_ovf), .drop_cnt(a_drop)
   );

   midi_event_decoder #(.CHAN_MASK(16'h0001)) dut_b (
      .clk(clk), .rst(rst), .byte_valid(byte_valid), .byte_data(byte_data),
      .evt_valid(b_valid), .evt_ready(evt_ready), .evt_type(b_type),
      .evt_chan(b_chan), .evt_d1(b_d1), .evt_d2(b_d2),
      .overflow(b_ovf), .drop_cnt(b_drop)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      if (obs !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end else begin
         $display("ok   %s: %0h", tag, obs);
      end
   endtask

   // Called on a negedge; returns on the following negedge.
   task automatic send_byte(input logic [7:0] b);
      byte_valid = 1'b1;
      byte_data  = b;
      @(negedge clk);
      byte_valid = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic expect_a(input string tag, input logic [2:0] t, input logic [3:0] c,
                           input logic [6:0] d1, input logic [6:0] d2);
      int k;
      k = 0;
      while (!a_valid && k < 8) begin
         @(negedge clk);
         k++;
      end
      chk({tag, ".valid"}, a_valid, 1);
      chk({tag, ".type"},  a_type, t);
      chk({tag, ".chan"},  a_chan, c);
      chk({tag, ".d1"},    a_d1, d1);
      chk({tag, ".d2"},    a_d2, d2);
      evt_ready = 1'b1;
      @(negedge clk);
      evt_ready = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      @(negedge clk);
      do_reset();

      // Reset state
      chk("rst.valid", a_valid, 0);
      chk("rst.type",  a_type, 0);
      chk("rst.chan",  a_chan, 0);
      chk("rst.d1",    a_d1, 0);
      chk("rst.d2",    a_d2, 0);
      chk("rst.ovf",   a_ovf, 0);
      chk("rst.drop",  a_drop, 0);

      // 90 3C 64: evt_valid low one cycle after the last strobe, high after two
      send_byte(8'h90); send_byte(8'h3C); send_byte(8'h64);
      chk("lat.cyc1", a_valid, 0);
      @(negedge clk);
      chk("lat.cyc2", a_valid, 1);
      expect_a("non", 3'd1, 4'd0, 7'h3C, 7'h64);
      chk("non.empty", a_valid, 0);

      // Running status, velocity-0 note on becomes note off
      send_byte(8'h93); send_byte(8'h40); send_byte(8'h7F);
      send_byte(8'h41); send_byte(8'h00);
      expect_a("rs1", 3'd1, 4'd3, 7'h40, 7'h7F);
      expect_a("rs2", 3'd0, 4'd3, 7'h41, 7'h00);

      // Realtime byte in the middle is transparent; program change is 2-byte
      send_byte(8'h90); send_byte(8'h3C); send_byte(8'hF8); send_byte(8'h64);
      send_byte(8'hC5); send_byte(8'h07);
      expect_a("rt", 3'd1, 4'd0, 7'h3C, 7'h64);
      expect_a("prog", 3'd4, 4'd5, 7'h07, 7'h00);

      // Other message kinds, and a new status abandoning a partial message
      send_byte(8'hE2); send_byte(8'h10); send_byte(8'h40);
      expect_a("bend", 3'd6, 4'd2, 7'h10, 7'h40);
      send_byte(8'hD1); send_byte(8'h55);
      expect_a("chat", 3'd5, 4'd1, 7'h55, 7'h00);
      send_byte(8'hBF); send_byte(8'h07); send_byte(8'h64);
      expect_a("ctrl", 3'd3, 4'd15, 7'h07, 7'h64);
      send_byte(8'hA4); send_byte(8'h3C); send_byte(8'h20);
      expect_a("poly", 3'd2, 4'd4, 7'h3C, 7'h20);
      send_byte(8'h90); send_byte(8'h3C); send_byte(8'h80);
      send_byte(8'h45); send_byte(8'h12);
      expect_a("restat", 3'd0, 4'd0, 7'h45, 7'h12);

      // Sysex skipped and running status cleared
      send_byte(8'hF0); send_byte(8'h7E); send_byte(8'h01); send_byte(8'hF7);
      send_byte(8'h3C); send_byte(8'h64);
      idle(4);
      chk("sysex.none", a_valid, 0);

      // Overflow: six messages into a 4-deep FIFO with no consumer
      do_reset();
      send_byte(8'h90);
      for (int n = 1; n <= 6; n++) begin
         send_byte(8'(n)); send_byte(8'h10);
      end
      idle(2);
      chk("ovf.flag", a_ovf, 1);
      chk("ovf.drop", a_drop, 2);

      // Full FIFO with a pop in the push cycle: push succeeds, no drop
      send_byte(8'h07); send_byte(8'h10);
      evt_ready = 1'b1;
      @(negedge clk);
      evt_ready = 1'b0;
      idle(1);
      chk("pp.drop", a_drop, 2);

      // Drop counter saturates
      for (int n = 0; n < 260; n++) begin
         send_byte(8'h20); send_byte(8'h10);
      end
      idle(2);
      chk("sat.drop", a_drop, 255);
      expect_a("drain2", 3'd1, 4'd0, 7'h02, 7'h10);
      expect_a("drain3", 3'd1, 4'd0, 7'h03, 7'h10);
      expect_a("drain4", 3'd1, 4'd0, 7'h04, 7'h10);
      expect_a("drain7", 3'd1, 4'd0, 7'h07, 7'h10);
      chk("drain.empty", a_valid, 0);

      // Channel mask: only the ch0 event reaches the masked instance
      do_reset();
      send_byte(8'h91); send_byte(8'h3C); send_byte(8'h64);
      send_byte(8'h90); send_byte(8'h3C); send_byte(8'h64);
      idle(2);
      chk("mask.valid", b_valid, 1);
      chk("mask.chan",  b_chan, 0);
      chk("mask.d1",    b_d1, 7'h3C);
      chk("mask.drop",  b_drop, 0);
      evt_ready = 1'b1;
      @(negedge clk);
      evt_ready = 1'b0;
      chk("mask.one", b_valid, 0);

      // Reset mid-message discards partial data and queued events
      do_reset();
      send_byte(8'h90); send_byte(8'h3C);
      do_reset();
      send_byte(8'h64);
      idle(3);
      chk("mrst.valid", b_valid, 0);
      chk("mrst.type",  b_type, 0);
      chk("mrst.d2",    b_d2, 0);
      chk("mrst.ovf",   b_ovf, 0);
      chk("mrst.a",     a_valid, 0);

      // A status byte strobed during reset is ignored
      rst = 1'b1; byte_valid = 1'b1; byte_data = 8'h90;
      @(negedge clk);
      rst = 1'b0; byte_valid = 1'b0;
      send_byte(8'h3C); send_byte(8'h64);
      idle(3);
      chk("rstbyte.none", a_valid, 0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/midi_event_decoder.md
MIDI_EVENT_DECODER -- requirements
Module: midi_event_decoder

Interface
REQ-001 Parameter CHAN_MASK, 16'hFFFF, bit n set = accept channel n (0-15); events on other channels are discarded.
REQ-002 Parameter FIFO_DEPTH, 4, event FIFO entries; power of two, 2..64.
REQ-003 Parameter VEL0_IS_OFF, 1, when 1 a Note On with velocity 0 is reported as Note Off.
REQ-004 clk  in  1  single clock for all logic.
REQ-005 rst  in  1  reset; synchronous, active-high.
REQ-006 byte_valid  in  1  one-cycle strobe; byte_data is valid this cycle (driven from uart_rx rdy).
REQ-007 byte_data  in  8  received MIDI byte.
REQ-008 evt_valid  out  1  FIFO head holds an event.
REQ-009 evt_ready  in  1  consumer accepts head; pop occurs when evt_valid && evt_ready.
REQ-010 evt_type  out  3  0 NOTE_OFF, 1 NOTE_ON, 2 POLY_AT, 3 CTRL, 4 PROG, 5 CHAN_AT, 6 BEND.
REQ-011 evt_chan  out  4  MIDI channel of head event.
REQ-012 evt_d1  out  7  first data byte (note, controller, program, pressure, bend LSB).
REQ-013 evt_d2  out  7  second data byte (velocity, value, bend MSB); 0 for 2-byte messages.
REQ-014 overflow  out  1  sticky; set when an event is dropped on a full FIFO.
REQ-015 drop_cnt  out  8  count of events dropped on a full FIFO; saturates at 255.

Function
REQ-016 Parser states: IDLE (no running status), WAIT_D1, WAIT_D2, SKIP (sysex or system common data).
REQ-017 Status 8x-Ex in any state: latch status, clear the partial message, go to WAIT_D1.
REQ-018 Bytes F8-FF (realtime): ignored; no change to state, running status or partial data.
REQ-019 Bytes F0-F7: clear running status; F0 goes to SKIP; all others go to IDLE.
REQ-020 Data byte (bit7 = 0) in IDLE or SKIP: discarded.
REQ-021 Data byte in WAIT_D1: Cx/Dx (2-byte) completes the message and returns to WAIT_D1; otherwise latch d1 and go to WAIT_D2.
REQ-022 Data byte in WAIT_D2: completes the message and returns to WAIT_D1; this implements running status.
REQ-023 On completion, events on channels masked off by CHAN_MASK are discarded with no FIFO push and no drop count.
REQ-024 9x with d2 = 0 and VEL0_IS_OFF = 1: push as NOTE_OFF with d2 = 0.
REQ-025 Push occurs in the cycle after the completing byte_valid; evt_valid rises 1 cycle after the push (2 cycles after the strobe) when the FIFO is empty.
REQ-026 FIFO: first-word-fall-through; evt_* outputs are stable while evt_valid && !evt_ready.
REQ-027 Push and pop in the same cycle are both performed; on a full FIFO, a simultaneous pop makes room and the push succeeds.
REQ-028 Push on a full FIFO with no pop: drop the event, set overflow, increment drop_cnt (saturating).
REQ-029 Pointers wrap modulo FIFO_DEPTH; occupancy counter is log2(FIFO_DEPTH)+1 bits.
REQ-030 byte_valid is accepted every cycle; back-to-back strobes are legal.

Reset
REQ-031 On rst: parser to IDLE, running status cleared, FIFO emptied, evt_valid=0, evt_type/chan/d1/d2=0, overflow=0, drop_cnt=0.
REQ-032 rst asserted mid-message discards the partial message and all queued events; a byte strobed in the rst cycle is ignored.

Structure
REQ-033 Shared package midi_pkg holds the evt_type enum, the event struct {type, chan, d1, d2}, and status-nibble constants.
REQ-034 One sub-module, midi_evt_fifo, parametrised by DEPTH, with synchronous active-high reset and a valid/ready pop interface.

Verification
REQ-035 Bytes 90 3C 64 -> one event NOTE_ON ch0 d1=3C d2=64; evt_valid 2 cycles after the 64 strobe.
REQ-036 Bytes 93 40 7F 41 00 (running status, VEL0_IS_OFF=1) -> NOTE_ON ch3 40/7F, then NOTE_OFF ch3 41/00.
REQ-037 Bytes 90 3C F8 64, then C5 07 -> NOTE_ON ch0 3C/64 (realtime transparent), then PROG ch5 d1=07 d2=00.
REQ-038 Bytes F0 7E 01 F7 3C 64 -> no events (sysex skipped, running status cleared).
REQ-039 FIFO_DEPTH=4, evt_ready=0, six complete messages -> 4 queued, overflow=1, drop_cnt=2; drain preserves order.
REQ-040 CHAN_MASK=16'h0001, bytes 91 3C 64 then 90 3C 64 -> only the ch0 event is queued; rst after 90 3C -> no event, all outputs 0.
